// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: merges UART and board button pulses, owns UART switch toggles and, with
// UART_ECHO_EN defined, echoes each accepted UART command through a small FIFO and TX handshake.
module uart_cmd_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_btn_r,
   input  logic       uart_btn_l,
   input  logic       uart_btn_u,
   input  logic       uart_btn_d,
   input  logic       uart_sw_mode,
   input  logic       uart_sw_sel_mode,
   input  logic       uart_sw_sel_display,
   input  logic       brd_btn_r,
   input  logic       brd_btn_l,
   input  logic       brd_btn_u,
   input  logic       brd_btn_d,
   input  logic [2:0] brd_sw,
   input  logic       tx_busy,
   output logic       btn_r,
   output logic       btn_l,
   output logic       btn_u,
   output logic       btn_d,
   output logic       sw_mode,
   output logic       sw_sel_mode,
   output logic       sw_sel_display,
   output logic       tx_start,
   output logic [7:0] tx_data
);
   logic [3:0] brd, uart, brd_pick, uart_pick, bus_d, bus_q, pend_d, pend_q;
   logic [2:0] tog_d, tog_q, sw_d, sw_q, uart_sw;
   logic       merged, uart_acc, store;

   // Buses are one-hot with bit 0 = r (highest priority) .. bit 3 = d; lowest set bit wins.
   always_comb begin
      brd       = {brd_btn_d, brd_btn_u, brd_btn_l, brd_btn_r};
      uart      = {uart_btn_d, uart_btn_u, uart_btn_l, uart_btn_r};
      uart_sw   = {uart_sw_sel_display, uart_sw_sel_mode, uart_sw_mode};
      brd_pick  = brd & (~brd + 4'd1);
      uart_pick = uart & (~uart + 4'd1);
      merged    = |(brd_pick & uart_pick);
      uart_acc  = |uart_pick && (merged || !(|pend_q));
      store     = |uart_pick && !merged && |brd_pick && !(|pend_q);
      bus_d     = |brd_pick ? brd_pick : (|pend_q ? pend_q : uart_pick);
      pend_d    = store ? uart_pick : (|brd_pick ? pend_q : 4'b0000);
      tog_d     = tog_q ^ uart_sw;
      sw_d      = brd_sw ^ tog_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_q  <= '0;
         pend_q <= '0;
         tog_q  <= '0;
         sw_q   <= '0;
      end else begin
         bus_q  <= bus_d;
         pend_q <= pend_d;
         tog_q  <= tog_d;
         sw_q   <= sw_d;
      end
   end

   assign {btn_d, btn_u, btn_l, btn_r}          = bus_q;
   assign {sw_sel_display, sw_sel_mode, sw_mode} = sw_q;

`ifdef UART_ECHO_EN
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
   state_t        state_d, state_q;
   logic [2:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q;
   logic [2:0]    code;
   logic [7:0]    data_d, data_q;
   logic          push_req, push, pop;

   function automatic logic [7:0] ascii(input logic [2:0] c);
      case (c)
         3'd0:    return 8'h72;
         3'd1:    return 8'h6C;
         3'd2:    return 8'h75;
         3'd3:    return 8'h64;
         3'd4:    return 8'h30;
         3'd5:    return 8'h31;
         default: return 8'h32;
      endcase
   endfunction

   // Only the first accepted command of a cycle is echoed: button, then toggles by index.
   always_comb begin
      code     = uart_acc ? {1'b0, uart_pick[3] | uart_pick[2], uart_pick[3] | uart_pick[1]} :
                 uart_sw_mode ? 3'd4 : uart_sw_sel_mode ? 3'd5 : 3'd6;
      push_req = uart_acc | (|uart_sw);
      pop      = state_q == IDLE && cnt_q != '0 && !tx_busy;
      push     = push_req && (cnt_q != FULL || pop);
      state_d  = state_q;
      data_d   = data_q;
      case (state_q)
         IDLE: if (pop) begin
            state_d = START;
            data_d  = ascii(mem_q[rp_q]);
         end
         START:     state_d = WAIT_BUSY;
         WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
         default:   state_d = tx_busy ? WAIT_DONE : IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         wp_q    <= wp_q + AW'(push);
         rp_q    <= rp_q + AW'(pop);
         cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign tx_start = state_q == START;
   assign tx_data  = data_q;
`else
   logic unused_ok;
   assign unused_ok = ^{tx_busy, uart_acc};
   assign tx_start  = 1'b0;
   assign tx_data   = 8'h00;
`endif
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: scoreboarded bench for uart_cmd_ctrl; echo expectations follow UART_ECHO_EN.
module tb_uart_cmd_ctrl;
   logic       clk = 1'b0, rst = 1'b1, tx_busy = 1'b0;
   logic [3:0] ub = '0, bb = '0;
   logic [2:0] us = '0, brd_sw = '0;
   logic       btn_r, btn_l, btn_u, btn_d, sw_mode, sw_sel_mode, sw_sel_display, tx_start;
   logic [7:0] tx_data;
   int         total = 0, bad = 0, n_start = 0, busy_len = 4;
   logic [3:0] exp_btn[$];
   logic [7:0] exp_tx[$];
   logic [3:0] mon_b, mon_e;
   logic [7:0] mon_t;
`ifdef UART_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .uart_btn_r(ub[0]), .uart_btn_l(ub[1]), .uart_btn_u(ub[2]), .uart_btn_d(ub[3]),
      .uart_sw_mode(us[0]), .uart_sw_sel_mode(us[1]), .uart_sw_sel_display(us[2]),
      .brd_btn_r(bb[0]), .brd_btn_l(bb[1]), .brd_btn_u(bb[2]), .brd_btn_d(bb[3]),
      .brd_sw(brd_sw), .tx_busy(tx_busy),
      .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
      .sw_mode(sw_mode), .sw_sel_mode(sw_sel_mode), .sw_sel_display(sw_sel_display),
      .tx_start(tx_start), .tx_data(tx_data)
   );

   // Output monitor: every button pulse and tx_start is matched against the scoreboard queues.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         mon_b = {btn_d, btn_u, btn_l, btn_r};
         if (mon_b != 4'b0000) begin
            total++;
            if (exp_btn.size() == 0) begin
               bad++;
               $display("FAIL btn_unexpected got=%b want=none", mon_b);
            end else begin
               mon_e = exp_btn.pop_front();
               if (mon_b !== mon_e) begin
                  bad++;
                  $display("FAIL btn_order got=%b want=%b", mon_b, mon_e);
               end
            end
         end
         if (tx_start) begin
            n_start++;
            total++;
            if (exp_tx.size() == 0) begin
               bad++;
               $display("FAIL echo_unexpected got=%h want=none", tx_data);
            end else begin
               mon_t = exp_tx.pop_front();
               if (tx_data !== mon_t) begin
                  bad++;
                  $display("FAIL echo_data got=%h want=%h", tx_data, mon_t);
               end
            end
         end
      end
   end

   // Transmitter model: busy for busy_len cycles after each start, independent of rst.
   initial forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
         tx_busy = 1'b1;
         repeat (busy_len) @(negedge clk);
         tx_busy = 1'b0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] u, input logic [3:0] b, input logic [2:0] s);
      ub = u; bb = b; us = s;
      @(negedge clk);
      ub = '0; bb = '0; us = '0;
   endtask

   task automatic uart_cmd(input logic [3:0] u, input logic [7:0] ch);
      exp_btn.push_back(u);
      if (ECHO) exp_tx.push_back(ch);
      drive(u, 4'b0000, 3'b000);
   endtask

   task automatic test_reset;
      rst = 1'b1; brd_sw = 3'b101;
      cyc(3);
      rst = 1'b0;
      cyc(1);
      total++;
      if ({btn_d, btn_u, btn_l, btn_r} !== 4'b0000) begin
         bad++; $display("FAIL reset_btn got=%b want=0000", {btn_d, btn_u, btn_l, btn_r});
      end
      total++;
      if ({sw_sel_display, sw_sel_mode, sw_mode} !== 3'b101) begin
         bad++; $display("FAIL reset_sw got=%b want=101", {sw_sel_display, sw_sel_mode, sw_mode});
      end
      total++;
      if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
         bad++; $display("FAIL reset_tx got start=%b data=%h want start=0 data=00", tx_start, tx_data);
      end
      cyc(3);
   endtask

   task automatic test_merge;
      int n0;
      n0 = n_start;
      exp_btn.push_back(4'b0001);
      exp_btn.push_back(4'b0100);
      if (ECHO) exp_tx.push_back(8'h75);
      drive(4'b0100, 4'b0001, 3'b000);
      total++;
      if (btn_r !== 1'b1 || btn_u !== 1'b0) begin
         bad++; $display("FAIL merge_cyc1 got r=%b u=%b want r=1 u=0", btn_r, btn_u);
      end
      cyc(1);
      total++;
      if (btn_u !== 1'b1 || btn_r !== 1'b0) begin
         bad++; $display("FAIL merge_cyc2 got r=%b u=%b want r=0 u=1", btn_r, btn_u);
      end
      cyc(20);
      total++;
      if (n_start - n0 !== (ECHO ? 1 : 0)) begin
         bad++; $display("FAIL merge_echo_count got=%0d want=%0d", n_start - n0, ECHO ? 1 : 0);
      end
   endtask

   task automatic test_toggle;
      brd_sw = 3'b000;
      cyc(2);
      total++;
      if (sw_mode !== 1'b0) begin bad++; $display("FAIL tog_init got=%b want=0", sw_mode); end
      for (int k = 0; k < 2; k++) begin
         if (ECHO) exp_tx.push_back(8'h30);
         drive(4'b0000, 4'b0000, 3'b001);
         total++;
         if (sw_mode !== k[0]) begin
            bad++; $display("FAIL tog_early%0d got=%b want=%b", k, sw_mode, k[0]);
         end
         cyc(1);
         total++;
         if (sw_mode !== ~k[0]) begin
            bad++; $display("FAIL tog_flip%0d got=%b want=%b", k, sw_mode, ~k[0]);
         end
         cyc(8);
      end
      cyc(10);
   endtask

   task automatic test_back_to_back;
      // Board r with UART d, then UART l while d is still pending: l is dropped.
      exp_btn.push_back(4'b0001); exp_btn.push_back(4'b1000);
      if (ECHO) exp_tx.push_back(8'h64);
      drive(4'b1000, 4'b0001, 3'b000);
      drive(4'b0010, 4'b0000, 3'b000);
      total++;
      if (btn_d !== 1'b1) begin bad++; $display("FAIL pend_issue got d=%b want 1", btn_d); end
      cyc(1);
      total++;
      if ({btn_d, btn_u, btn_l, btn_r} !== 4'b0000) begin
         bad++; $display("FAIL pend_drop got=%b want=0000", {btn_d, btn_u, btn_l, btn_r});
      end
      cyc(12);
      // Board pulses in two cycles keep u pending; d arriving meanwhile is dropped.
      exp_btn.push_back(4'b0001); exp_btn.push_back(4'b0010); exp_btn.push_back(4'b0100);
      if (ECHO) exp_tx.push_back(8'h75);
      drive(4'b0100, 4'b0001, 3'b000);
      drive(4'b1000, 4'b0010, 3'b000);
      cyc(12);
      // Same button from both sources merges; simultaneous board r and d gives only r.
      exp_btn.push_back(4'b0100);
      if (ECHO) exp_tx.push_back(8'h75);
      drive(4'b0100, 4'b0100, 3'b000);
      exp_btn.push_back(4'b0001);
      drive(4'b0000, 4'b1001, 3'b000);
      cyc(12);
      // Button and toggle in one cycle: both applied, only the button is echoed.
      exp_btn.push_back(4'b0010);
      if (ECHO) exp_tx.push_back(8'h6C);
      drive(4'b0010, 4'b0000, 3'b010);
      cyc(1);
      total++;
      if (sw_sel_mode !== 1'b1) begin bad++; $display("FAIL tog_with_btn got=%b want=1", sw_sel_mode); end
      if (ECHO) exp_tx.push_back(8'h31);
      drive(4'b0000, 4'b0000, 3'b010);
      cyc(12);
   endtask

   task automatic test_fifo_full;
      int n0;
      n0 = n_start;
      busy_len = 200;
      for (int k = 0; k < 6; k++) begin
         exp_btn.push_back(4'b0010);
         if (ECHO && k < 5) exp_tx.push_back(8'h6C);
         drive(4'b0010, 4'b0000, 3'b000);
         cyc(2);
      end
      for (int i = 0; i < 2000 && exp_tx.size() != 0; i++) @(negedge clk);
      cyc(300);
      total++;
      if (n_start - n0 !== (ECHO ? 5 : 0)) begin
         bad++; $display("FAIL fifo_full_count got=%0d want=%0d", n_start - n0, ECHO ? 5 : 0);
      end
   endtask

   task automatic test_reset_mid;
      int n0, n1;
      n0 = n_start;
      busy_len = 200;
      for (int k = 0; k < 3; k++) begin
         exp_btn.push_back(4'b0001);
         if (ECHO && k == 0) exp_tx.push_back(8'h72);
         drive(4'b0001, 4'b0000, 3'b000);
         cyc(2);
      end
      cyc(10);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      n1 = n_start;
      cyc(300);
      total++;
      if (n_start !== n1) begin bad++; $display("FAIL rst_mid_start got=%0d want=%0d", n_start, n1); end
      total++;
      if (n1 - n0 !== (ECHO ? 1 : 0)) begin
         bad++; $display("FAIL rst_mid_before got=%0d want=%0d", n1 - n0, ECHO ? 1 : 0);
      end
      busy_len = 4;
      uart_cmd(4'b0100, 8'h75);
      cyc(20);
      total++;
      if (n_start - n1 !== (ECHO ? 1 : 0)) begin
         bad++; $display("FAIL rst_mid_flush got=%0d want=%0d", n_start - n1, ECHO ? 1 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_merge();
      test_toggle();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid();
      for (int i = 0; i < 2000 && (exp_tx.size() != 0 || exp_btn.size() != 0); i++) @(negedge clk);
      total++;
      if (exp_btn.size() != 0) begin bad++; $display("FAIL btn_left got=%0d want=0", exp_btn.size()); end
      total++;
      if (exp_tx.size() != 0) begin bad++; $display("FAIL echo_left got=%0d want=0", exp_tx.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
